early_debounce_fsm: RTL and testbench

//  Early-detection switch debouncer for one mechanical input. On the first

---
 rtl/early_debounce_fsm.sv | 69 ++++++
 tb/tb_early_debounce_fsm.sv | 135 +++++++++++++
 2 files changed

// File: rtl/early_debounce_fsm.sv
// Early-detection switch debouncer: db follows the first edge of sw at once,
// then sw is ignored for three m_tick boundaries so contact bounce is masked.
module early_debounce_fsm #(
    parameter int TICK_CYCLES = 1_000_000,
    parameter int CNT_W       = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db,
    output logic m_tick
);

    typedef enum logic [2:0] {
        ZERO, W1_1, W1_2, W1_3, ONE, W0_1, W0_2, W0_3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    state_t           state_q;
    logic             db_q;

    // Free-running timebase; FSM activity never restarts it.
    assign m_tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (m_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_INC;
        end
    end

    // db only changes when a wait phase is entered, so it stays a pure state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ZERO;
            db_q    <= 1'b0;
        end else begin
            case (state_q)
                ZERO: if (sw) begin
                    state_q <= W1_1;
                    db_q    <= 1'b1;
                end
                W1_1: if (m_tick) state_q <= W1_2;
                W1_2: if (m_tick) state_q <= W1_3;
                W1_3: if (m_tick) state_q <= ONE;
                ONE: if (!sw) begin
                    state_q <= W0_1;
                    db_q    <= 1'b0;
                end
                W0_1: if (m_tick) state_q <= W0_2;
                W0_2: if (m_tick) state_q <= W0_3;
                W0_3: if (m_tick) state_q <= ZERO;
                default: begin
                    state_q <= ZERO;
                    db_q    <= 1'b0;
                end
            endcase
        end
    end

    assign db = db_q;

endmodule

// File: tb/tb_early_debounce_fsm.sv
// Directed bench for early_debounce_fsm (TICK_CYCLES=10): a behavioural model
// pushes the expected db/m_tick per edge to a queue, popped after each edge.
module tb_early_debounce_fsm;

    logic clk = 1'b0;
    logic reset, sw;
    logic db, m_tick;

    early_debounce_fsm #(.TICK_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .sw(sw), .db(db), .m_tick(m_tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] exp_q[$];

    // Model: lockout as a count of remaining tick boundaries.
    int   m_cnt  = 0;
    int   m_lock = 0;
    logic m_db   = 1'b0;
    int   cyc    = 0;
    int   last_tick = -1;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic s);
        logic [1:0] e;
        logic tick;
        reset = r;
        sw    = s;
        if (r) begin
            m_cnt = 0; m_db = 1'b0; m_lock = 0;
        end else begin
            tick = (m_cnt == 9);
            if (m_lock > 0) begin
                if (tick) m_lock--;
            end else if (s != m_db) begin
                m_db = s;
                m_lock = 3;
            end
            m_cnt = tick ? 0 : m_cnt + 1;
        end
        exp_q.push_back({m_db, (m_cnt == 9) ? 1'b1 : 1'b0});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("db", db, e[1]);
        chk("m_tick", m_tick, e[0]);
        if (r) begin
            cyc = 0;
            last_tick = -1;
        end else begin
            cyc++;
            if (m_tick === 1'b1) begin
                if (last_tick < 0) chki("first_tick_cycle", cyc, 9);
                else chki("tick_period", cyc - last_tick, 10);
                last_tick = cyc;
            end
        end
    endtask

    task automatic run(input int n, input logic s);
        for (int i = 0; i < n; i++) step(1'b0, s);
    endtask

    initial begin
        reset = 1'b1;
        sw    = 1'b0;
        #2;
        // 1: reset state and timebase phase
        step(1'b1, 1'b0);
        chk("reset_db", db, 1'b0);
        chk("reset_tick", m_tick, 1'b0);
        run(30, 1'b0);

        // 2: clean press, db rises on the first edge and never moves again
        step(1'b0, 1'b1);
        chk("press_latency", db, 1'b1);
        run(40, 1'b1);
        chk("press_held", db, 1'b1);
        run(40, 1'b0);
        chk("release_clean", db, 1'b0);

        // 3: bouncy press
        for (int i = 0; i < 20; i++) step(1'b0, ((i / 3) % 2) ? 1'b0 : 1'b1);
        chk("bouncy_press", db, 1'b1);
        run(40, 1'b1);

        // 4: bouncy release
        step(1'b0, 1'b0);
        chk("release_latency", db, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, (i % 2) ? 1'b0 : 1'b1);
        run(40, 1'b0);
        chk("bouncy_release", db, 1'b0);

        // 5: short pulse holds db for the full lockout, then falls
        run(2, 1'b1);
        run(50, 1'b0);
        chk("short_pulse_end", db, 1'b0);

        // 6: reset in the middle of a press wait
        while (m_lock != 2) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("midwait_reset_db", db, 1'b0);
        chk("midwait_reset_tick", m_tick, 1'b0);
        step(1'b0, 1'b1);
        chk("post_reset_press", db, 1'b1);
        run(35, 1'b1);

        // Random sw with occasional reset
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));

        chki("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
